// File: rtl/port_rx_lookup_fsm_if.sv
// Handshake bundle between the port RX FIFO, lookup engine, ring tap and port_rx_lookup_fsm.
// master is the surrounding environment; slave is the FSM itself.
interface port_rx_lookup_fsm_if #(
    parameter int pdp_sz    = 64,
    parameter int num_ports = 4
);
    logic                 prx_srdy;
    logic [pdp_sz-1:0]    prx_data;
    logic                 prx_drdy;
    logic                 lkr_srdy;
    logic [47:0]          lkr_data;
    logic                 lkr_drdy;
    logic                 lks_srdy;
    logic [num_ports-1:0] lks_data;
    logic                 lks_drdy;
    logic                 lfli_srdy;
    logic [num_ports-1:0] lfli_data;
    logic                 lfli_drdy;
    logic                 lprx_srdy;
    logic [pdp_sz-1:0]    lprx_data;
    logic                 lprx_drdy;
    logic [15:0]          fwd_cnt;
    logic [15:0]          drop_cnt;

    modport master (
        output prx_srdy, prx_data, input  prx_drdy,
        input  lkr_srdy, lkr_data, output lkr_drdy,
        output lks_srdy, lks_data, input  lks_drdy,
        input  lfli_srdy, lfli_data, output lfli_drdy,
        input  lprx_srdy, lprx_data, output lprx_drdy,
        input  fwd_cnt, drop_cnt
    );

    modport slave (
        input  prx_srdy, prx_data, output prx_drdy,
        output lkr_srdy, lkr_data, input  lkr_drdy,
        input  lks_srdy, lks_data, output lks_drdy,
        output lfli_srdy, lfli_data, input  lfli_drdy,
        output lprx_srdy, lprx_data, input  lprx_drdy,
        output fwd_cnt, drop_cnt
    );
endinterface

// File: rtl/port_rx_lookup_fsm.sv
// Per-port RX control: looks up the DA of each packet, hands the forwarding vector to the
// ring tap, then streams the packet through (or discards it when nobody else wants it).
module port_rx_lookup_fsm #(
    parameter int pdp_sz    = 64,
    parameter int num_ports = 4,
    parameter int portnum   = 0
) (
    input  logic                clk,
    input  logic                reset,
    port_rx_lookup_fsm_if.slave bus
);
    localparam logic [1:0] PCC_SOP = 2'b01;

    localparam logic [5:0] ST_IDLE = 6'b000001;
    localparam logic [5:0] ST_REQ  = 6'b000010;
    localparam logic [5:0] ST_WAIT = 6'b000100;
    localparam logic [5:0] ST_FLI  = 6'b001000;
    localparam logic [5:0] ST_PASS = 6'b010000;
    localparam logic [5:0] ST_DROP = 6'b100000;

    // A packet is never reflected back onto its own port.
    localparam logic [num_ports-1:0] OWN_MASK = num_ports'(1) << portnum;

    logic [5:0]           r_state;
    logic [5:0]           w_state_nxt;
    logic [47:0]          r_da;
    logic [num_ports-1:0] r_vec;
    logic [15:0]          r_fwd_cnt;
    logic [15:0]          r_drop_cnt;

    logic [1:0]           w_pcc;
    logic                 w_eop;
    logic                 w_prx_xfer;
    logic                 w_fwd_inc;
    logic                 w_drop_inc;

    logic                 w_prx_drdy;
    logic                 w_lkr_srdy;
    logic [47:0]          w_lkr_data;
    logic                 w_lks_drdy;
    logic                 w_lfli_srdy;
    logic [num_ports-1:0] w_lfli_data;
    logic                 w_lprx_srdy;
    logic [pdp_sz-1:0]    w_lprx_data;

    assign w_pcc      = bus.prx_data[pdp_sz-1 -: 2];
    // EOP and BADEOP both have the top code bit set; a mid-packet SOP is therefore plain data.
    assign w_eop      = w_pcc[1];
    assign w_prx_xfer = bus.prx_srdy & w_prx_drdy;
    assign w_fwd_inc  = (r_state == ST_PASS) & w_prx_xfer & w_eop;
    assign w_drop_inc = ((r_state == ST_IDLE) & w_prx_xfer) |
                        ((r_state == ST_DROP) & w_prx_xfer & w_eop);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = (bus.prx_srdy && w_pcc == PCC_SOP) ? ST_REQ : ST_IDLE;
            ST_REQ:  w_state_nxt = bus.lkr_drdy ? ST_WAIT : ST_REQ;
            ST_WAIT: w_state_nxt = bus.lks_srdy ? ST_FLI : ST_WAIT;
            ST_FLI:  w_state_nxt = !bus.lfli_drdy ? ST_FLI :
                                   (r_vec != '0) ? ST_PASS : ST_DROP;
            ST_PASS: w_state_nxt = (w_prx_xfer && w_eop) ? ST_IDLE : ST_PASS;
            ST_DROP: w_state_nxt = (w_prx_xfer && w_eop) ? ST_IDLE : ST_DROP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_prx_drdy  = 1'b0;
        w_lkr_srdy  = 1'b0;
        w_lkr_data  = '0;
        w_lks_drdy  = 1'b0;
        w_lfli_srdy = 1'b0;
        w_lfli_data = '0;
        w_lprx_srdy = 1'b0;
        w_lprx_data = '0;
        case (r_state)
            // SOP is left in the FIFO so PASS can forward it as the first word.
            ST_IDLE: w_prx_drdy = bus.prx_srdy && (w_pcc != PCC_SOP);
            ST_REQ: begin
                w_lkr_srdy = 1'b1;
                w_lkr_data = r_da;
            end
            ST_WAIT: w_lks_drdy = 1'b1;
            ST_FLI: begin
                w_lfli_srdy = 1'b1;
                w_lfli_data = r_vec;
            end
            ST_PASS: begin
                w_lprx_srdy = bus.prx_srdy;
                w_lprx_data = bus.prx_srdy ? bus.prx_data : '0;
                w_prx_drdy  = bus.lprx_drdy;
            end
            ST_DROP: w_prx_drdy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_da       <= '0;
            r_vec      <= '0;
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.prx_srdy && w_pcc == PCC_SOP)
                r_da <= bus.prx_data[47:0];
            if (r_state == ST_WAIT && bus.lks_srdy)
                r_vec <= bus.lks_data & ~OWN_MASK;
            if (w_fwd_inc && r_fwd_cnt != 16'hFFFF)
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
            if (w_drop_inc && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Handshakes are held low while in reset so nothing transfers during it.
    assign bus.prx_drdy  = w_prx_drdy  & ~reset;
    assign bus.lkr_srdy  = w_lkr_srdy  & ~reset;
    assign bus.lkr_data  = reset ? '0 : w_lkr_data;
    assign bus.lks_drdy  = w_lks_drdy  & ~reset;
    assign bus.lfli_srdy = w_lfli_srdy & ~reset;
    assign bus.lfli_data = reset ? '0 : w_lfli_data;
    assign bus.lprx_srdy = w_lprx_srdy & ~reset;
    assign bus.lprx_data = reset ? '0 : w_lprx_data;
    assign bus.fwd_cnt   = r_fwd_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_port_rx_lookup_fsm.sv
// Bench for port_rx_lookup_fsm: directed vector table, hand sequences for reset/stray/saturation,
// and a randomly stalled packet stream checked against a packet-level expectation model.
module tb_port_rx_lookup_fsm;
    localparam int PDP = 64;
    localparam int NP  = 4;
    localparam int PN  = 0;
    localparam logic [1:0] PCC_DATA = 2'b00;
    localparam logic [1:0] PCC_SOP  = 2'b01;
    localparam logic [1:0] PCC_EOP  = 2'b10;
    localparam logic [1:0] PCC_BAD  = 2'b11;

    typedef logic [PDP-1:0] word_t;
    typedef logic [NP-1:0]  vec_t;

    typedef struct {
        logic [47:0] da;
        int          len;
        vec_t        res;
        vec_t        exp_vec;
        int          exp_fwd;
        int          exp_drop;
    } vec_rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    port_rx_lookup_fsm_if #(.pdp_sz(PDP), .num_ports(NP)) bus ();
    port_rx_lookup_fsm #(.pdp_sz(PDP), .num_ports(NP), .portnum(PN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    word_t       src_q[$];
    vec_t        res_q[$];
    logic [47:0] exp_da_q[$];
    vec_t        exp_vec_q[$];
    word_t       exp_lprx_q[$];
    int          exp_fwd   = 0;
    int          exp_drop  = 0;
    int unsigned stall_pct = 0;
    int          lprx_seen = 0;
    logic        lks_pend  = 1'b0;
    vec_t        lks_val   = '0;
    vec_t        last_lfli = '1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic go();
        return $urandom_range(0, 99) >= stall_pct;
    endfunction

    function automatic int sat(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    function automatic word_t rnd_word(input logic [1:0] pcc);
        word_t w;
        w = {$urandom(), $urandom()};
        w[PDP-1 -: 2] = pcc;
        return w;
    endfunction

    // Packet-level model: forwarding vector is the lookup result minus our own port;
    // a nonzero vector forwards every word unchanged, a zero vector drops the packet.
    task automatic push_pkt(input logic [47:0] da, input int len, input vec_t res, input bit mid_sop);
        word_t w;
        vec_t  v;
        word_t pk[$];
        w = rnd_word(PCC_SOP);
        w[47:0] = da;
        pk.push_back(w);
        for (int i = 1; i < len - 1; i++)
            pk.push_back(rnd_word((mid_sop && $urandom_range(0, 2) == 0) ? PCC_SOP : PCC_DATA));
        pk.push_back(rnd_word($urandom_range(0, 1) == 1 ? PCC_BAD : PCC_EOP));
        v = res & ~(vec_t'(1) << PN);
        exp_da_q.push_back(da);
        res_q.push_back(res);
        exp_vec_q.push_back(v);
        foreach (pk[i]) begin
            src_q.push_back(pk[i]);
            if (v != '0) exp_lprx_q.push_back(pk[i]);
        end
        if (v != '0) exp_fwd = sat(exp_fwd);
        else         exp_drop = sat(exp_drop);
    endtask

    task automatic push_stray(input logic [1:0] pcc);
        src_q.push_back(rnd_word(pcc));
        exp_drop = sat(exp_drop);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(src_q.size() == 0 && exp_lprx_q.size() == 0 &&
                               exp_vec_q.size() == 0 && exp_da_q.size() == 0 && !lks_pend)) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drained"}, 64'(n < budget), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_fwd  = 0;
        exp_drop = 0;
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string name, input int fwd, input int drop);
        chk({name, "_fwd_cnt"},  64'(bus.fwd_cnt),  64'(fwd));
        chk({name, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(drop));
    endtask

    // Environment: samples transfers at negedge, drives the next cycle's inputs 1 unit after posedge.
    initial begin : env
        bit hs_prx, hs_lkr, hs_lks;
        bus.prx_srdy  = 1'b0;
        bus.prx_data  = '0;
        bus.lkr_drdy  = 1'b0;
        bus.lks_srdy  = 1'b0;
        bus.lks_data  = '0;
        bus.lfli_drdy = 1'b0;
        bus.lprx_drdy = 1'b0;
        forever begin
            @(negedge clk);
            hs_prx = 1'b0;
            hs_lkr = 1'b0;
            hs_lks = 1'b0;
            if (reset) begin
                chk("reset_handshakes_low",
                    64'({bus.prx_drdy, bus.lkr_srdy, bus.lks_drdy, bus.lfli_srdy, bus.lprx_srdy}), 64'd0);
            end else begin
                if (!bus.lkr_srdy)  chk("lkr_data_zero",  64'(bus.lkr_data),  64'd0);
                if (!bus.lfli_srdy) chk("lfli_data_zero", 64'(bus.lfli_data), 64'd0);
                if (!bus.lprx_srdy) chk("lprx_data_zero", 64'(bus.lprx_data), 64'd0);
                hs_prx = bus.prx_srdy & bus.prx_drdy;
                hs_lks = bus.lks_srdy & bus.lks_drdy;
                if (bus.lkr_srdy && bus.lkr_drdy) begin
                    hs_lkr = 1'b1;
                    chk("lkr_expected", 64'(exp_da_q.size() > 0), 64'd1);
                    if (exp_da_q.size() > 0) chk("lkr_da", 64'(bus.lkr_data), 64'(exp_da_q.pop_front()));
                end
                if (bus.lfli_srdy && bus.lfli_drdy) begin
                    last_lfli = bus.lfli_data;
                    chk("lfli_expected", 64'(exp_vec_q.size() > 0), 64'd1);
                    if (exp_vec_q.size() > 0) chk("lfli_vec", 64'(bus.lfli_data), 64'(exp_vec_q.pop_front()));
                end
                if (bus.lprx_srdy && bus.lprx_drdy) begin
                    lprx_seen++;
                    chk("lprx_expected", 64'(exp_lprx_q.size() > 0), 64'd1);
                    if (exp_lprx_q.size() > 0) chk("lprx_word", bus.lprx_data, exp_lprx_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (hs_prx) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                bus.prx_srdy = 1'b0;
                bus.prx_data = '0;
            end
            if (!bus.prx_srdy && src_q.size() > 0 && go()) begin
                bus.prx_srdy = 1'b1;
                bus.prx_data = src_q[0];
            end
            if (hs_lkr && res_q.size() > 0) begin
                lks_pend = 1'b1;
                lks_val  = res_q.pop_front();
            end
            if (hs_lks) begin
                lks_pend     = 1'b0;
                bus.lks_srdy = 1'b0;
                bus.lks_data = '0;
            end
            if (lks_pend && !bus.lks_srdy && go()) begin
                bus.lks_srdy = 1'b1;
                bus.lks_data = lks_val;
            end
            bus.lkr_drdy  = go();
            bus.lfli_drdy = go();
            bus.lprx_drdy = go();
        end
    end

    initial begin : watchdog
        #900000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        vec_rec_t tbl [6];
        int base, n, t0, lat;
        tbl[0] = '{48'h0000_0A0B_0C0D, 3, 4'b0111, 4'b0110, 1, 0};
        tbl[1] = '{48'h1234_5678_9ABC, 5, 4'b0001, 4'b0000, 1, 1};
        tbl[2] = '{48'hFFFF_FFFF_FFFF, 2, 4'b1111, 4'b1110, 2, 1};
        tbl[3] = '{48'h0000_0000_0000, 3, 4'b0000, 4'b0000, 2, 2};
        tbl[4] = '{48'h8000_0000_0001, 4, 4'b1000, 4'b1000, 3, 2};
        tbl[5] = '{48'h0000_0000_0001, 6, 4'b0011, 4'b0010, 4, 2};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_cnt("reset", 0, 0);
        chk("reset_lkr_srdy",  64'(bus.lkr_srdy),  64'd0);
        chk("reset_lfli_srdy", 64'(bus.lfli_srdy), 64'd0);
        chk("reset_lprx_srdy", 64'(bus.lprx_srdy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            last_lfli = '1;
            push_pkt(tbl[i].da, tbl[i].len, tbl[i].res, i == 5);
            wait_drain($sformatf("vec%0d", i), 200);
            chk($sformatf("vec%0d_lfli", i), 64'(last_lfli), 64'(tbl[i].exp_vec));
            chk_cnt($sformatf("vec%0d", i), tbl[i].exp_fwd, tbl[i].exp_drop);
        end

        // SOP presented to first lprx_srdy with no stalls anywhere.
        t0  = -1;
        lat = -1;
        push_pkt(48'h0000_1111_2222, 2, 4'b0100, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (t0 < 0 && bus.prx_srdy && bus.prx_data[PDP-1 -: 2] == PCC_SOP) t0 = c;
            if (t0 >= 0 && bus.lprx_srdy) begin
                lat = c - t0;
                break;
            end
        end
        chk("sop_to_lprx_latency", 64'(lat), 64'd4);
        wait_drain("latency", 200);
        chk_cnt("latency", 5, 2);

        // Reset during PASS after word 2 of 6: remaining four words become strays.
        base = lprx_seen;
        push_pkt(48'h00AA_BBCC_DDEE, 6, 4'b0110, 1'b0);
        n = 0;
        while (lprx_seen < base + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("midpkt_reached_word2", 64'(n < 100), 64'd1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_cnt("midpkt_reset", 0, 0);
        chk("midpkt_idle_discards", 64'(bus.prx_drdy), 64'd1);
        exp_lprx_q.delete();
        exp_fwd  = 0;
        exp_drop = 4;
        wait_drain("midpkt", 200);
        chk_cnt("midpkt_after", 0, 4);

        // Stray words in IDLE, then a normal packet.
        do_reset();
        push_stray(PCC_DATA);
        push_stray(PCC_DATA);
        push_stray(PCC_EOP);
        wait_drain("stray", 200);
        chk_cnt("stray", 0, 3);
        last_lfli = '1;
        push_pkt(48'h0000_0A0B_0C0D, 4, 4'b1010, 1'b0);
        wait_drain("stray_next", 200);
        chk("stray_next_lfli", 64'(last_lfli), 64'(4'b1010));
        chk_cnt("stray_next", 1, 3);

        // 100 packets under random stalls on every channel.
        do_reset();
        stall_pct = 40;
        for (int p = 0; p < 100; p++)
            push_pkt({$urandom(), 16'($urandom())}, int'($urandom_range(2, 8)),
                     vec_t'($urandom_range(0, 15)), 1'b1);
        wait_drain("random", 30000);
        stall_pct = 0;
        chk_cnt("random", exp_fwd, exp_drop);
        chk("random_total_pkts", 64'(bus.fwd_cnt) + 64'(bus.drop_cnt), 64'd100);

        // drop_cnt saturation from a preloaded value.
        do_reset();
        force dut.r_drop_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_drop_cnt;
        chk("sat_preload", 64'(bus.drop_cnt), 64'h0000_0000_0000_FFFE);
        exp_drop = 65534;
        push_stray(PCC_DATA);
        push_stray(PCC_BAD);
        push_stray(PCC_DATA);
        wait_drain("sat", 200);
        chk("sat_drop_cnt", 64'(bus.drop_cnt), 64'h0000_0000_0000_FFFF);
        chk("sat_model", 64'(bus.drop_cnt), 64'(exp_drop));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
